// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Also holds the sign-extension helper used for PC-relative branch offsets.
package fetch_pkg;

  localparam int PCW_D = 10;
  localparam int IW_D  = 9;
  localparam int LA_D  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  // Sign-extends the low w bits of v to 32 bits.
  function automatic logic [31:0] sext_off(input logic [31:0] v, input int w);
    logic [31:0] t;
    t = v << (32 - w);
    return 32'($signed(t) >>> (32 - w));
  endfunction

endpackage

// File: rtl/fetch_branch_lut.sv
// Branch target table: asynchronous clear, synchronous write, combinational read.
module fetch_branch_lut #(
  parameter int PCW = 10,
  parameter int LA  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [LA-1:0]  waddr,
  input  logic [PCW-1:0] wdata,
  input  logic [LA-1:0]  raddr,
  output logic [PCW-1:0] rdata
);

  logic [PCW-1:0] mem [1<<LA];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < (1 << LA); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, fetched-instruction register, branch redirect
// through a programmable target table, and start/halt sequencing.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PCW = PCW_D,
  parameter int IW  = IW_D,
  parameter int LA  = LA_D
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic [PCW-1:0] StartAddr,
  input  logic           Stall,
  input  logic           BranchTaken,
  input  logic           BranchRel,
  input  logic [LA-1:0]  BranchIdx,
  input  logic           HaltReq,
  input  logic           LutWe,
  input  logic [LA-1:0]  LutAddr,
  input  logic [PCW-1:0] LutData,
  output logic [PCW-1:0] InstrAddr,
  input  logic [IW-1:0]  InstrRdData,
  output logic [IW-1:0]  InstrOut,
  output logic [PCW-1:0] PcOut,
  output logic           InstrValid,
  output logic           Done,
  output state_e         DbgState
);

  state_e         state;
  logic [PCW-1:0] pc;
  logic [PCW-1:0] pc_out;
  logic [IW-1:0]  instr_out;
  logic           instr_valid;
  logic           done;
  logic [PCW-1:0] lut_rd;
  logic [31:0]    off_ext;
  logic [PCW-1:0] branch_target;

  // The table only changes while the core is not executing.
  fetch_branch_lut #(.PCW(PCW), .LA(LA)) u_lut (
    .clk   (Clk),
    .rst   (Reset),
    .we    (LutWe && (state != RUN)),
    .waddr (LutAddr),
    .wdata (LutData),
    .raddr (BranchIdx),
    .rdata (lut_rd)
  );

  assign off_ext       = sext_off(32'(lut_rd), PCW);
  assign branch_target = BranchRel ? (pc_out + off_ext[PCW-1:0]) : lut_rd;

  // Handshake: InstrValid qualifies InstrOut/PcOut for the decoder, and Stall is
  // the decoder's not-ready: while it is high the pair is held and redirects wait.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      pc          <= '0;
      pc_out      <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          instr_valid <= 1'b0;
          if (Start) begin
            pc    <= StartAddr;
            done  <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          if (Stall) begin
            // hold everything
          end else if (instr_valid && HaltReq) begin
            instr_valid <= 1'b0;
            done        <= 1'b1;
            state       <= HALT;
          end else if (instr_valid && BranchTaken) begin
            pc          <= branch_target;
            instr_valid <= 1'b0;
          end else begin
            instr_out   <= InstrRdData;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign InstrAddr  = pc;
  assign InstrOut   = instr_out;
  assign PcOut      = pc_out;
  assign InstrValid = instr_valid;
  assign Done       = done;
  assign DbgState   = state;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the decoder/RegFile pair.
- Holds the program counter and drives the instruction-memory address.
- Registers the fetched instruction for the decoder.
- Resolves taken branches through a small programmable target LUT.
- Sequences start/halt of the processor and reports completion through Done.

Parameters:
PCW, 10, program counter / instruction address width
IW, 9, instruction width
LA, 4, branch LUT index width (2**LA entries of PCW bits)

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  pulse: begin execution at StartAddr (IDLE/HALT only)
StartAddr  input  PCW  first instruction address
Stall  input  1  freeze PC and instruction register this cycle
BranchTaken  input  1  decoder: instruction in InstrOut is a taken branch
BranchRel  input  1  1 = PC-relative (PcOut + signed LUT entry), 0 = absolute LUT entry
BranchIdx  input  LA  LUT index for the branch target
HaltReq  input  1  decoder: instruction in InstrOut is halt
LutWe  input  1  LUT write enable (accepted in IDLE/HALT only)
LutAddr  input  LA  LUT write index
LutData  input  PCW  LUT write data
InstrAddr  output  PCW  instruction-memory address (= PC, combinational)
InstrRdData  input  IW  instruction-memory read data (combinational, same cycle)
InstrOut  output  IW  registered instruction to the decoder
PcOut  output  PCW  address of InstrOut
InstrValid  output  1  InstrOut is live and must be executed
Done  output  1  high while in HALT

Behaviour:
- Reset, asynchronous: state=IDLE, PC=0, InstrOut=0, PcOut=0, InstrValid=0, Done=0, all LUT entries=0.
- State IDLE:
  - InstrValid=0.
  - Start: PC<=StartAddr, go to RUN.
  - LutWe: lut[LutAddr]<=LutData.
- State RUN, evaluated each edge in priority order:
  1. Stall=1: hold PC, InstrOut, PcOut, InstrValid. BranchTaken and HaltReq are ignored; the decoder re-asserts them after the stall.
  2. InstrValid=1 and HaltReq=1: go to HALT, InstrValid<=0, Done<=1, PC held.
  3. InstrValid=1 and BranchTaken=1:
     - PC<=target; InstrValid<=0 (the instruction fetched this cycle is squashed).
     - Absolute target = lut[BranchIdx].
     - Relative target = PcOut + sign-extended lut[BranchIdx], truncated to PCW bits (wraps mod 2**PCW).
  4. Otherwise: InstrOut<=InstrRdData, PcOut<=PC, InstrValid<=1, PC<=PC+1. PC wraps from 2**PCW-1 to 0.
- Latency:
  - First valid instruction appears 1 cycle after the Start edge.
  - A taken branch costs exactly 1 bubble cycle.
  - Branch target instruction is valid 2 cycles after the branch was presented.
- BranchTaken and HaltReq are ignored whenever InstrValid=0.
- Start in RUN is ignored.
- LutWe in RUN is ignored (LUT is static during execution).
- State HALT:
  - Done=1, InstrValid=0, PC frozen.
  - Start: PC<=StartAddr, Done<=0, go to RUN.
  - LutWe is accepted.
- Reset asserted mid-RUN: all state clears immediately, without waiting for a clock edge; an in-flight branch is lost.
- Stall and Start together in IDLE: Start wins; Stall has effect only in RUN.

Decomposition:
- Package fetch_pkg: state enum {IDLE, RUN, HALT}, default widths PCW/IW/LA as localparams, and a sign-extension helper function for LUT offsets.
- Sub-module fetch_branch_lut:
  - 2**LA x PCW register array.
  - Asynchronous reset to 0, synchronous write, combinational read.
  - Instantiated once.
- Top module contains the FSM and the PC/instruction registers.

Test Plan:
1. Reset, then Start with StartAddr=5 and ROM[i]=i -> InstrAddr=5 in cycle 0; InstrOut=5/PcOut=5/InstrValid=1 at cycle 1; 6 at cycle 2; 7 at cycle 3.
2. Absolute branch:
   - Setup: lut[3]=20 written in IDLE, then Start at 0.
   - Stimulus: BranchTaken=1, BranchRel=0, BranchIdx=3 while PcOut=2.
   - Response: next cycle InstrValid=0; following cycle PcOut=20, InstrOut=ROM[20].
3. Relative branch with wrap:
   - Setup: PCW=10, lut[1]=10'h3FE (-2).
   - Stimulus: branch taken at PcOut=1.
   - Response: target 0x3FF; PcOut=1023 valid; next sequential PcOut=0.
4. Stall=1 for 3 cycles while PcOut=4 with BranchTaken=1 asserted -> InstrOut/PcOut/PC unchanged and no redirect. Stall drop with BranchTaken still high -> redirect taken.
5. HaltReq with InstrValid=1 at PcOut=8:
   - Next edge: Done=1, InstrValid=0, InstrAddr frozen at 9.
   - LutWe accepted in HALT.
   - Start with StartAddr=0: Done=0, PcOut=0 valid one cycle later.
6. Reset asserted asynchronously mid-RUN (between edges) -> outputs zero immediately, state IDLE. LutWe during RUN before the reset -> LUT contents unchanged.
